dma_bus_controller: RTL and testbench

- Moves a block of words from an external device buffer into main memory, with the CPU and its caches sharing the same memory bus.
- Acquires the bus with a BR/BG handshake and writes one word per memory handshake.
- Bursts are BLOCK_WORDS long, so the CPU can cycle-steal between bursts.
- Drives the BR and dma_end signals that the pipeline hazard/stall logic consumes.

---
 rtl/dma_bus_controller.sv | 109 ++++++++++
 tb/tb_dma_bus_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_controller.sv
// rtl/dma_bus_controller.sv - DMA engine moving a device buffer into memory over a BR/BG-shared bus
module dma_bus_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_length,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  input  logic                 cpu_bus_want,
  output logic [LEN_WIDTH-1:0] dev_idx,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 dma_end
);

  localparam int BURST_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WORD_SIZE-1:0] base_q;
  logic [LEN_WIDTH-1:0] remain_q;
  logic [LEN_WIDTH-1:0] idx_q;
  logic [BURST_W-1:0]   burst_q;

  // Losing the grant mid-word must drop the write in that same cycle, hence BG in the decode.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign BR        = (state_q == S_REQ) || (state_q == S_XFER);
  assign mem_write = (state_q == S_XFER) && BG;
  assign dma_end   = (state_q == S_DONE);
  assign dev_idx   = idx_q;
  assign mem_addr  = base_q + WORD_SIZE'(idx_q);
  assign mem_data  = dev_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      burst_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_length == '0) begin
              state_q <= S_DONE;
            end else begin
              base_q   <= cmd_addr;
              remain_q <= cmd_length;
              idx_q    <= '0;
              burst_q  <= '0;
              state_q  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (BG) state_q <= S_XFER;
        end
        S_XFER: begin
          // Without the grant the pending word is not counted and is retried after re-grant.
          if (!BG) begin
            state_q <= S_REQ;
          end else if (mem_ready) begin
            idx_q    <= idx_q + LEN_WIDTH'(1);
            remain_q <= remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) begin
              burst_q <= '0;
              state_q <= S_DONE;
            end else if (burst_q == BURST_LAST) begin
              burst_q <= '0;
              if (cpu_bus_want) state_q <= S_RELEASE;
            end else begin
              burst_q <= burst_q + BURST_W'(1);
            end
          end
        end
        S_RELEASE: begin
          if (!BG && !cpu_bus_want) state_q <= S_REQ;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_controller.sv
// tb/tb_dma_bus_controller.sv - scoreboard bench for dma_bus_controller
module tb_dma_bus_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_length = '0;
  logic        cmd_ready, BR, BG, cpu_bus_want, mem_write, mem_ready, busy, dma_end;
  logic [15:0] dev_idx, dev_data, mem_addr, mem_data;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t e, o;
  int  n_run = 0;
  int  n_fail = 0;
  int  br_falls, rel_cycles, unstable, endc;
  bit  br_seen, found;

  // Bus/CPU/memory behaviour knobs read by the driver process
  bit          bg_auto = 1'b1;
  bit          bg_force = 1'b0;
  bit          cpu_auto = 1'b0;
  int          rdy_mode = 0;
  logic [15:0] stall_idx = 16'hFFFF;
  int          ws = 0;
  int          rel_cnt = 0;

  dma_bus_controller #(.WORD_SIZE(16), .BLOCK_WORDS(4), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .cmd_ready(cmd_ready), .BR(BR), .BG(BG),
    .cpu_bus_want(cpu_bus_want), .dev_idx(dev_idx), .dev_data(dev_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .dma_end(dma_end)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dev_word(input logic [15:0] i);
    return 16'hC0DE ^ (i * 16'h0101);
  endfunction

  assign dev_data = dev_word(dev_idx);

  initial begin
    BG = 1'b0;
    mem_ready = 1'b0;
    cpu_bus_want = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      BG = bg_auto ? BR : bg_force;
      if (cpu_auto) begin
        if (BR) begin
          cpu_bus_want = 1'b1;
          rel_cnt = 0;
        end else if (busy) begin
          rel_cnt++;
          if (rel_cnt >= 2) cpu_bus_want = 1'b0;
        end else begin
          cpu_bus_want = 1'b0;
        end
      end else begin
        cpu_bus_want = 1'b0;
      end
      #1;
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: begin
          if (mem_write) begin
            if (ws == 3) begin
              mem_ready = 1'b1;
              ws = 0;
            end else begin
              mem_ready = 1'b0;
              ws++;
            end
          end else begin
            mem_ready = 1'b0;
            ws = 0;
          end
        end
        default: mem_ready = mem_write && (dev_idx != stall_idx);
      endcase
    end
  end

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] n);
    @(posedge clk);
    #3;
    cmd_addr = a;
    cmd_length = n;
    cmd_valid = 1'b1;
    @(posedge clk);
    #3;
    cmd_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a + 16'(i), dev_word(16'(i))});
  endtask

  // Observes the bus cycle by cycle (cycle 1 = first cycle after command acceptance).
  task automatic watch(input int max_cyc, input int inj_cyc, output int end_cyc);
    logic prev_br = 1'b0;
    logic prev_wait = 1'b0;
    logic [15:0] pa = '0, pd = '0;
    br_falls = 0; rel_cycles = 0; unstable = 0; br_seen = 1'b0; end_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        cmd_addr = 16'h0900;
        cmd_length = 16'd2;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (BR) br_seen = 1'b1;
      if (prev_br && !BR && !dma_end) br_falls++;
      if (busy && !BR && !dma_end) rel_cycles++;
      if (mem_write && prev_wait && (mem_addr !== pa || mem_data !== pd)) unstable++;
      if (mem_write && mem_ready) obs_q.push_back({mem_addr, mem_data});
      prev_wait = mem_write && !mem_ready;
      pa = mem_addr;
      pd = mem_data;
      prev_br = BR;
      if (dma_end) begin
        end_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_run++;
    if ({BR, mem_write, dma_end, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b", {BR, mem_write, dma_end, busy, cmd_ready}, 5'b00001);
    end
    n_run++;
    if (dev_idx !== 16'h0) begin n_fail++; $display("FAIL reset_dev_idx: got %h expected 0000", dev_idx); end
    n_run++;
    if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_q.delete(); obs_q.delete();
    push_exp(16'h0100, 12);
    send_cmd(16'h0100, 16'd12);
    watch(60, 0, endc);
    n_run++;
    if (endc !== 14) begin n_fail++; $display("FAIL basic_latency: got %0d expected 14", endc); end
    n_run++;
    if (br_falls !== 0) begin n_fail++; $display("FAIL basic_br_held: got %0d drops expected 0", br_falls); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL basic_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    @(negedge clk);
    n_run++;
    if ({dma_end, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL basic_end_pulse: got %b expected 001", {dma_end, busy, cmd_ready}); end
  endtask

  task automatic test_cycle_steal();
    exp_q.delete(); obs_q.delete();
    cpu_auto = 1'b1;
    push_exp(16'h0400, 12);
    send_cmd(16'h0400, 16'd12);
    watch(80, 0, endc);
    cpu_auto = 1'b0;
    n_run++;
    if (endc !== 20) begin n_fail++; $display("FAIL steal_latency: got %0d expected 20", endc); end
    n_run++;
    if (br_falls !== 2) begin n_fail++; $display("FAIL steal_br_drops: got %0d expected 2", br_falls); end
    n_run++;
    if (rel_cycles !== 4) begin n_fail++; $display("FAIL steal_release_cycles: got %0d expected 4", rel_cycles); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL steal_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL steal_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
  endtask

  task automatic test_wait_states();
    exp_q.delete(); obs_q.delete();
    rdy_mode = 1;
    push_exp(16'h0500, 5);
    send_cmd(16'h0500, 16'd5);
    watch(80, 0, endc);
    rdy_mode = 0;
    n_run++;
    if (endc !== 22) begin n_fail++; $display("FAIL wait_latency: got %0d expected 22", endc); end
    n_run++;
    if (unstable !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes expected 0", unstable); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wait_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL wait_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
  endtask

  task automatic test_bg_drop();
    exp_q.delete(); obs_q.delete();
    rdy_mode = 2;
    stall_idx = 16'd2;
    push_exp(16'h0200, 4);
    send_cmd(16'h0200, 16'd4);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_write && mem_ready) obs_q.push_back({mem_addr, mem_data});
      if (mem_write && dev_idx == 16'd2) found = 1'b1;
    end
    n_run++;
    if (!found) begin n_fail++; $display("FAIL drop_reach_word2: got timeout expected word 2 in flight"); end
    bg_auto = 1'b0;
    bg_force = 1'b0;
    @(negedge clk);
    n_run++;
    if ({BR, mem_write} !== 2'b10) begin n_fail++; $display("FAIL drop_mem_write: got %b expected 10", {BR, mem_write}); end
    @(negedge clk);
    n_run++;
    if ({BR, mem_write, busy} !== 3'b101) begin n_fail++; $display("FAIL drop_req_state: got %b expected 101", {BR, mem_write, busy}); end
    stall_idx = 16'hFFFF;
    bg_auto = 1'b1;
    watch(40, 0, endc);
    rdy_mode = 0;
    n_run++;
    if (endc < 0) begin n_fail++; $display("FAIL drop_done: got timeout expected dma_end"); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL drop_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
  endtask

  task automatic test_zero_len();
    exp_q.delete(); obs_q.delete();
    send_cmd(16'h1234, 16'd0);
    watch(10, 0, endc);
    n_run++;
    if (endc !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", endc); end
    n_run++;
    if (br_seen !== 1'b0) begin n_fail++; $display("FAIL zero_no_br: got %b expected 0", br_seen); end
    n_run++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_no_write: got %0d expected 0", obs_q.size()); end
    @(negedge clk);
    n_run++;
    if ({dma_end, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_pulse_width: got %b expected 00", {dma_end, busy}); end
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_addr [4];
    wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF; wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({wrap_addr[i], dev_word(16'(i))});
    send_cmd(16'hFFFE, 16'd4);
    watch(30, 0, endc);
    n_run++;
    if (endc !== 6) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 6", endc); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
  endtask

  task automatic test_ignore_busy();
    exp_q.delete(); obs_q.delete();
    push_exp(16'h0300, 6);
    send_cmd(16'h0300, 16'd6);
    watch(40, 3, endc);
    n_run++;
    if (endc !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 8", endc); end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignore_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL ignore_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    found = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (BR || busy) found = 1'b1;
    end
    n_run++;
    if (found) begin n_fail++; $display("FAIL ignore_no_second: got activity expected idle"); end
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); obs_q.delete();
    send_cmd(16'h0600, 16'd8);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_write && dev_idx == 16'd3) found = 1'b1;
    end
    n_run++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach_xfer: got timeout expected word 3 in flight"); end
    reset = 1'b1;
    @(negedge clk);
    n_run++;
    if ({BR, mem_write, busy, dma_end} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0000", {BR, mem_write, busy, dma_end}); end
    n_run++;
    if ({dev_idx, mem_addr} !== 32'h0) begin n_fail++; $display("FAIL rstmid_regs: got %h expected 00000000", {dev_idx, mem_addr}); end
    reset = 1'b0;
    watch(6, 0, endc);
    n_run++;
    if (endc !== -1 || br_seen) begin n_fail++; $display("FAIL rstmid_no_end: got end=%0d br=%b expected end=-1 br=0", endc, br_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cycle_steal();
    test_wait_states();
    test_bg_drop();
    test_zero_len();
    test_wrap();
    test_ignore_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
